// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared types and constants for the instruction-cache refill path.
//   fill_state_t  : refill sequencer states
//   DATA_W        : memory beat width
//   LINE_W        : cache line width
//   BEATS         : beats per line
//   LINE_OFF_BITS : byte-offset bits inside a line
// -----------------------------------------------------------------------------
package icache_pkg;

  localparam int unsigned DATA_W        = 32;
  localparam int unsigned LINE_W        = 128;
  localparam int unsigned BEATS         = LINE_W / DATA_W;
  localparam int unsigned LINE_OFF_BITS = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    BEAT  = 3'd2,
    WRITE = 3'd3,
    DRAIN = 3'd4
  } fill_state_t;

endpackage

// File: rtl/icache_line_asm.sv
// -----------------------------------------------------------------------------
// icache_line_asm
// Line assembly buffer: one 128-bit register written one 32-bit word slot at a
// time, cleared at the start of each refill.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : clear the whole line (wins over we_i)
//   we_i       : write wdata_i into word slot slot_i
//   slot_i     : word slot, word i lives in bits [32i+31:32i]
//   wdata_i    : beat data
//   line_o     : assembled line (registered)
// -----------------------------------------------------------------------------
module icache_line_asm
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [1:0]        slot_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [LINE_W-1:0] line_o
);

  logic [LINE_W-1:0] line_q;
  logic [LINE_W-1:0] line_d;

  // Next-line computation: clear, slot write or hold.
  always_comb begin
    line_d = line_q;
    if (clr_i) begin
      line_d = {LINE_W{1'b0}};
    end else if (we_i) begin
      line_d[slot_i*DATA_W +: DATA_W] = wdata_i;
    end else begin
      line_d = line_q;
    end
  end

  // Line buffer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= {LINE_W{1'b0}};
    end else begin
      line_q <= line_d;
    end
  end

  assign line_o = line_q;

endmodule

// File: rtl/icache_fill_ctrl.sv
// -----------------------------------------------------------------------------
// icache_fill_ctrl
// Instruction-cache miss/refill sequencer. On a lookup miss it requests a
// 4-beat burst, assembles the 128-bit line and writes it into the cache. An
// IFQ abort discards the fill; beats already requested are drained so the
// memory port stays in step. All outputs are registered.
//
// Optional build macro: ICACHE_CRITICAL_WORD_FIRST_EN
//   defined   : burst starts at the missing word, beats fill slots in wrap
//               order, crit_valid_o/crit_data_o forward the first beat
//               (one cycle after it arrives).
//   undefined : burst starts at the line base, ascending slots, no crit ports.
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   miss_valid_i/addr_i  : lookup miss and its PC
//   abort_i              : IFQ redirect, discard fill in flight
//   fill_busy_o          : controller not idle
//   mem_req_o/addr_o     : burst request (held until mem_gnt_i) and address
//   mem_gnt_i            : request accepted
//   mem_rvalid_i/rdata_i : read beat
//   cache_we_o           : one-cycle line write strobe
//   cache_waddr_o/wdata_o: line address and data
//   fill_done_o          : pulse coincident with cache_we_o
//   fill_err_o           : pulse on memory timeout
// -----------------------------------------------------------------------------
module icache_fill_ctrl
  import icache_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_valid_i,
  input  logic [31:0]       miss_addr_i,
  input  logic              abort_i,
  output logic              fill_busy_o,
  output logic              mem_req_o,
  output logic [31:0]       mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              cache_we_o,
  output logic [31:0]       cache_waddr_o,
  output logic [LINE_W-1:0] cache_wdata_o,
  output logic              fill_done_o,
  output logic              fill_err_o
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  ,
  output logic              crit_valid_o,
  output logic [DATA_W-1:0] crit_data_o
`endif
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  fill_state_t       state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [31:0]       base_q, base_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [1:0]        start_q, start_d;
  logic              fill_busy_q, fill_busy_d;
  logic              mem_req_q, mem_req_d;
  logic              cache_we_q, cache_we_d;
  logic              fill_err_q, fill_err_d;

  logic              counting_s, active_s, timeout_s, beat_last_s;
  logic              buf_clr_s, buf_we_s;
  logic [1:0]        slot_s;
  logic              unused_addr_s;

  // Low address bits that do not select a word are never needed.
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  assign unused_addr_s = ^miss_addr_i[1:0];
`else
  assign unused_addr_s = ^miss_addr_i[3:0];
`endif

  // Sequencing: next state, counters and registered-output next values.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    base_d     = base_q;
    mem_addr_d = mem_addr_q;
    start_d    = start_q;
    buf_clr_s  = 1'b0;
    buf_we_s   = 1'b0;

    // wait_cnt runs while waiting on memory and clears on any memory response.
    counting_s  = (state_q == REQ) || (state_q == BEAT) || (state_q == DRAIN);
    active_s    = ((state_q == REQ) && mem_gnt_i) ||
                  (((state_q == BEAT) || (state_q == DRAIN)) && mem_rvalid_i);
    timeout_s   = counting_s && !active_s && (wait_q == WAIT_W'(MAX_WAIT));
    beat_last_s = (beat_q == 2'(BEATS - 1));
    slot_s      = start_q + beat_q;  // wraps mod 4

    if (counting_s && !active_s && !timeout_s) begin
      wait_d = wait_q + WAIT_W'(1);
    end else begin
      wait_d = {WAIT_W{1'b0}};
    end

    case (state_q)
      IDLE: begin
        if (miss_valid_i && !abort_i) begin
          state_d   = REQ;
          base_d    = {miss_addr_i[31:LINE_OFF_BITS], 4'b0000};
          beat_d    = 2'b00;
          buf_clr_s = 1'b1;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
          mem_addr_d = {miss_addr_i[31:2], 2'b00};
          start_d    = miss_addr_i[3:2];
`else
          mem_addr_d = {miss_addr_i[31:LINE_OFF_BITS], 4'b0000};
          start_d    = 2'b00;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (timeout_s) begin
          state_d = IDLE;
        end else if (mem_gnt_i) begin
          // A grant in the abort cycle means beats are coming: drain them.
          beat_d  = 2'b00;
          state_d = abort_i ? DRAIN : BEAT;
        end else if (abort_i) begin
          state_d = IDLE;
        end else begin
          state_d = REQ;
        end
      end
      BEAT: begin
        if (timeout_s) begin
          state_d = IDLE;
        end else if (mem_rvalid_i) begin
          // A beat in the abort cycle still counts toward the burst.
          beat_d   = beat_q + 2'b01;
          buf_we_s = !abort_i;
          if (beat_last_s) begin
            state_d = abort_i ? IDLE : WRITE;
          end else if (abort_i) begin
            state_d = DRAIN;
          end else begin
            state_d = BEAT;
          end
        end else if (abort_i) begin
          state_d = DRAIN;
        end else begin
          state_d = BEAT;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      DRAIN: begin
        if (timeout_s) begin
          state_d = IDLE;
        end else if (mem_rvalid_i) begin
          beat_d  = beat_q + 2'b01;
          state_d = beat_last_s ? IDLE : DRAIN;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    fill_busy_d = (state_d != IDLE);
    mem_req_d   = (state_d == REQ);
    cache_we_d  = (state_d == WRITE);
    fill_err_d  = timeout_s;
  end

  // Sequencer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_q      <= 2'b00;
      wait_q      <= {WAIT_W{1'b0}};
      base_q      <= 32'h0000_0000;
      mem_addr_q  <= 32'h0000_0000;
      start_q     <= 2'b00;
      fill_busy_q <= 1'b0;
      mem_req_q   <= 1'b0;
      cache_we_q  <= 1'b0;
      fill_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      wait_q      <= wait_d;
      base_q      <= base_d;
      mem_addr_q  <= mem_addr_d;
      start_q     <= start_d;
      fill_busy_q <= fill_busy_d;
      mem_req_q   <= mem_req_d;
      cache_we_q  <= cache_we_d;
      fill_err_q  <= fill_err_d;
    end
  end

  icache_line_asm u_line_asm (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (buf_clr_s),
    .we_i    (buf_we_s),
    .slot_i  (slot_s),
    .wdata_i (mem_rdata_i),
    .line_o  (cache_wdata_o)
  );

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  logic              crit_valid_q, crit_valid_d;
  logic [DATA_W-1:0] crit_data_q, crit_data_d;

  // First beat of a live fill is forwarded; an abort in that cycle suppresses it.
  always_comb begin
    crit_valid_d = (state_q == BEAT) && mem_rvalid_i && (beat_q == 2'b00) && !abort_i;
    if (crit_valid_d) begin
      crit_data_d = mem_rdata_i;
    end else begin
      crit_data_d = crit_data_q;
    end
  end

  // Critical-word forwarding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crit_valid_q <= 1'b0;
      crit_data_q  <= {DATA_W{1'b0}};
    end else begin
      crit_valid_q <= crit_valid_d;
      crit_data_q  <= crit_data_d;
    end
  end

  assign crit_valid_o = crit_valid_q;
  assign crit_data_o  = crit_data_q;
`endif

  assign fill_busy_o   = fill_busy_q;
  assign mem_req_o     = mem_req_q;
  assign mem_addr_o    = mem_addr_q;
  assign cache_we_o    = cache_we_q;
  assign fill_done_o   = cache_we_q;
  assign cache_waddr_o = base_q;
  assign fill_err_o    = fill_err_q;

endmodule

// File: doc/icache_fill_ctrl.md
Name: icache_fill_ctrl

Overview:
- Miss/refill sequencer for the instruction cache.
- On a cache lookup miss it:
  - requests a 128-bit line from the memory port as a burst of 32-bit beats;
  - assembles the line;
  - writes it into the cache through the cache write port.
- Sits between the i-cache and the external memory interface, alongside the IFQ.
- Honours the IFQ `abort` on branch redirects by suppressing the write of a stale line.

Parameters:
- DATA_W, 32, memory beat width in bits.
- LINE_W, 128, cache line width; BEATS = LINE_W/DATA_W = 4.
- MAX_WAIT, 255, idle cycles tolerated while waiting for mem_gnt/mem_rvalid before timeout.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- miss_valid  in  1  cache lookup missed this cycle.
- miss_addr  in  32  PC of the missing fetch.
- abort  in  1  IFQ redirect; discard any fill in flight.
- fill_busy  out  1  controller not in IDLE.
- mem_req  out  1  burst request, held until granted.
- mem_addr  out  32  burst start address.
- mem_gnt  in  1  memory accepted the request.
- mem_rvalid  in  1  one read beat valid.
- mem_rdata  in  32  read beat data.
- cache_we  out  1  line write strobe, one cycle.
- cache_waddr  out  32  line address, {base[31:4],4'b0}.
- cache_wdata  out  128  assembled line; word i occupies bits [32i+31:32i].
- fill_done  out  1  one-cycle pulse coincident with cache_we.
- fill_err  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; beat_cnt=0; wait_cnt=0; line buffer 0.
  - All outputs 0.
  - A fill in progress is lost, with no write.
- IDLE:
  - miss_valid=1 and abort=0 → latch base address, go to REQ.
  - fill_busy rises the next cycle.
  - miss_valid is ignored in every other state.
- REQ:
  - mem_req=1, mem_addr=base, held stable until mem_gnt=1.
  - gnt=1 → BEAT, beat_cnt=0.
  - abort=1 with gnt=0 → IDLE; no memory transaction has started.
  - abort=1 with gnt=1 in the same cycle → DRAIN.
- BEAT:
  - Each mem_rvalid stores mem_rdata into word slot (start_word+beat_cnt) mod 4, then beat_cnt++.
  - The 4th beat → WRITE.
  - abort → DRAIN. Beats already counted are kept in the count, including a beat arriving in the abort cycle.
- WRITE (1 cycle):
  - cache_we=1, fill_done=1, cache_waddr/cache_wdata driven, then → IDLE.
  - abort in this cycle does not cancel the write; the line is valid data.
- DRAIN:
  - Consumes the remaining beats with no buffer writes and no cache_we.
  - → IDLE after the 4th total beat.
- Timeout:
  - wait_cnt increments in REQ/BEAT/DRAIN and clears on mem_gnt or mem_rvalid.
  - wait_cnt == MAX_WAIT → fill_err pulse, → IDLE, no write.
- Latency: with mem_gnt in REQ's first cycle and back-to-back beats, cache_we fires 6 cycles after miss_valid.
- mem_rvalid is ignored outside BEAT/DRAIN.
- beat_cnt is 2 bits plus a terminal flag; slot index wraps mod 4.

Optional Feature:
- Macro: ICACHE_CRITICAL_WORD_FIRST_EN.
- Defined:
  - mem_addr = {miss_addr[31:2],2'b0}; start_word = miss_addr[3:2].
  - Beats fill slots in wrap order, e.g. start 2 → slots 2,3,0,1.
  - Extra ports crit_valid (out 1) and crit_data (out 32) pulse with the first beat, for early forwarding to the IFQ.
  - crit_valid is suppressed after abort.
- Undefined:
  - mem_addr = line base; start_word = 0; ascending order.
  - No crit ports.

Decomposition:
- Package icache_pkg holds:
  - fill_state_t enum (IDLE, REQ, BEAT, WRITE, DRAIN);
  - constants DATA_W, LINE_W, BEATS, LINE_OFF_BITS=4.
- One sub-module: icache_line_asm.
  - Contains the 128-bit buffer with a slot-indexed 32-bit write and clear.
  - Keeps the FSM file focused on sequencing.

Test Plan:
- Miss at 0x0000_1234; gnt on the first REQ cycle; beats 0xA,0xB,0xC,0xD back-to-back → cache_we once, waddr 0x0000_1230, wdata 0x0000000D_0000000C_0000000B_0000000A, fill_done coincident, fill_busy falls the next cycle.
- Miss, then abort after beat 2 → state goes through DRAIN, consumes beats 3-4, no cache_we, fill_busy=0 after the 4th beat; a new miss is then accepted normally.
- Abort while mem_req is held with gnt=0 for 3 cycles → mem_req drops the next cycle, no beats are expected, the FSM returns to IDLE.
- No mem_rvalid for MAX_WAIT cycles after gnt → single fill_err pulse, no cache_we, IDLE; reassert miss → a fresh mem_req.
- rst_n asserted mid-BEAT → all outputs 0 immediately (asynchronously); after release, the same miss refetches the full line.
- With ICACHE_CRITICAL_WORD_FIRST_EN and miss 0x0000_1238 → mem_addr 0x0000_1238; beats land in slots 2,3,0,1; crit_valid pulses with beat 1 carrying its data.
